hilo_md_ctrl: RTL and testbench
===============================

Name: hilo_md_ctrl

Overview:
- Sequences the multiply/divide resource and owns the Hi/Lo register pair that the ALU reads through its mfhi/mflo selects.
- Accepts one mult/div/mthi/mtlo command per issue and computes the result.
- Holds busy for a fixed, parameterised latency, then commits Hi/Lo atomically.
- The pipeline hazard unit stalls any md command or mfhi/mflo while busy=1. The block supports cancellation on exception flush.

Parameters:
- MULT_LAT, 5, cycles busy is held for mult/multu (and madd family); legal 1..31.
- DIV_LAT, 10, cycles busy is held for div/divu; legal 1..31.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  command valid this cycle
- md_op  in  4  command: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo; 0111..1010 reserved for Optional Feature
- A1  in  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- A2  in  32  rt operand (divisor / multiplier)
- flush  in  1  cancel any in-flight operation
- busy  out  1  operation in flight
- Hi  out  32  Hi register, to ALU
- Lo  out  32  Lo register, to ALU

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - Hi=0, Lo=0, busy=0, state=IDLE, counter=0, pending result cleared.
  - Reset wins over start and flush, and aborts any in-flight operation.
- States:
  - IDLE: busy=0.
  - RUN: busy=1. A 5-bit counter holds the remaining cycles.
- Accept: start=1 in IDLE with a valid md_op, at edge T.
- mult/multu/div/divu:
  - At edge T, compute the result from A1/A2 and latch it into a pending {hi,lo} register.
  - Load the counter with MULT_LAT or DIV_LAT and go to RUN.
  - busy=1 for exactly LAT cycles (T+1 .. T+LAT).
  - At edge T+LAT, commit Hi/Lo, set busy to 0 and return to IDLE. New values are visible from cycle T+LAT+1.
  - Hi/Lo keep their old values throughout RUN.
- mthi/mtlo:
  - Write A1 to Hi or Lo at edge T.
  - busy never asserts and the state stays IDLE.
- Ignored commands, no state change:
  - start while in RUN (the hazard unit must prevent this).
  - md_op=none, or a reserved or unsupported code.
- Arithmetic:
  - mult: signed 32x32 to 64-bit product, Hi=[63:32], Lo=[31:0].
  - multu: same, unsigned.
  - div: Lo=quotient truncated toward zero, Hi=remainder with the dividend's sign.
  - divu: unsigned.
- Divide by zero (div or divu): Lo=32'hFFFFFFFF, Hi=A1.
- Signed overflow (div with A1=32'h80000000, A2=32'hFFFFFFFF): Lo=32'h80000000, Hi=0.
- flush=1:
  - In RUN: discard the pending result, return to IDLE next edge with busy=0, leave Hi/Lo unchanged.
  - In IDLE: any start in the same cycle is suppressed.
- flush on the commit edge (counter==1): flush wins, so no commit.
- LAT=1: busy is high for one cycle only.

Optional Feature:
- Macro: HILO_MADD_EN.
- Defined:
  - md_op 0111 madd, 1000 maddu, 1001 msub, 1010 msubu.
  - Result = {Hi,Lo} +/- (signed or unsigned A1*A2), 64-bit wrap.
  - The {Hi,Lo} accumulator term is the value held at acceptance edge T.
  - Latency is MULT_LAT.
- Undefined: codes 0111..1010 are ignored like other reserved codes, and the block contains no accumulator adder.

Decomposition:
- Package hilo_md_pkg holds:
  - the md_op localparams (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU);
  - the state encoding (ST_IDLE, ST_RUN);
  - the 5-bit counter width.
- One sub-module, hilo_md_calc: purely combinational. It takes md_op, A1, A2 and the current {Hi,Lo}, and returns the 64-bit result, including the divide-by-zero and overflow rules.
- The controller keeps the FSM, counter, pending register and Hi/Lo.

Test Plan:
- Reset, then mult A1=32'hFFFFFFFE (-2), A2=3 -> busy high 5 cycles; then Hi=32'hFFFFFFFF, Lo=32'hFFFFFFFA.
- multu A1=A2=32'hFFFFFFFF -> after 5 busy cycles Hi=32'hFFFFFFFE, Lo=32'h00000001.
- div A1=-7 (32'hFFFFFFF9), A2=2 -> busy 10 cycles; Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF.
- Division edge cases:
  - divu A1=5, A2=0 -> Lo=32'hFFFFFFFF, Hi=5.
  - div 32'h80000000 / 32'hFFFFFFFF -> Lo=32'h80000000, Hi=0.
- mthi A1=32'h12345678 -> Hi updated next cycle, busy stays 0. Then start div, assert flush on cycle 4 -> busy drops next edge, Hi stays 32'h12345678.
- During div RUN, issue start=1 with mult -> ignored. Assert reset_n=0 mid-RUN -> Hi=Lo=0, busy=0 the next cycle.
- (With HILO_MADD_EN) Hi=0, Lo=10, madd A1=3, A2=4 -> Lo=22, Hi=0 after 5 cycles.

Source files
------------

// File: rtl/hilo_md_pkg.sv
// -----------------------------------------------------------------------------
// hilo_md_pkg
// Shared definitions for the Hi/Lo multiply/divide controller:
//   - md_op command codes (MD_*)
//   - controller state encoding (ST_IDLE / ST_RUN)
//   - remaining-cycle counter width
//   - small op-class decode helpers
// Optional feature macro: HILO_MADD_EN (enables madd/maddu/msub/msubu decode).
// -----------------------------------------------------------------------------
package hilo_md_pkg;

   localparam int CNT_W = 5;

   localparam logic [3:0] MD_NONE  = 4'b0000;
   localparam logic [3:0] MD_MULT  = 4'b0001;
   localparam logic [3:0] MD_MULTU = 4'b0010;
   localparam logic [3:0] MD_DIV   = 4'b0011;
   localparam logic [3:0] MD_DIVU  = 4'b0100;
   localparam logic [3:0] MD_MTHI  = 4'b0101;
   localparam logic [3:0] MD_MTLO  = 4'b0110;
   localparam logic [3:0] MD_MADD  = 4'b0111;
   localparam logic [3:0] MD_MADDU = 4'b1000;
   localparam logic [3:0] MD_MSUB  = 4'b1001;
   localparam logic [3:0] MD_MSUBU = 4'b1010;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_t;

   // Commands that occupy the unit for MULT_LAT cycles.
   function automatic logic is_mult_op(input logic [3:0] op);
      logic r;
      r = 1'b0;
      case (op)
         MD_MULT, MD_MULTU: r = 1'b1;
`ifdef HILO_MADD_EN
         MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Commands that occupy the unit for DIV_LAT cycles.
   function automatic logic is_div_op(input logic [3:0] op);
      logic r;
      r = 1'b0;
      case (op)
         MD_DIV, MD_DIVU: r = 1'b1;
         default:         r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/hilo_md_calc.sv
// -----------------------------------------------------------------------------
// hilo_md_calc
// Purely combinational arithmetic for the Hi/Lo unit. Produces the 64-bit
// {hi,lo} result for the command on md_op, including the divide-by-zero and
// signed-overflow conventions.
// Optional feature macro: HILO_MADD_EN (accumulate forms use the hilo input).
// Ports:
//   md_op  in  4   command code
//   A1     in  32  rs operand (dividend / multiplicand)
//   A2     in  32  rt operand (divisor / multiplier)
//   hilo   in  64  current {Hi,Lo} (accumulator term)
//   result out 64  {hi,lo} result
// -----------------------------------------------------------------------------
module hilo_md_calc
   import hilo_md_pkg::*;
(
   input  logic [3:0]  md_op,
   input  logic [31:0] A1,
   input  logic [31:0] A2,
   input  logic [63:0] hilo,
   output logic [63:0] result
);

   logic [63:0] prod_s_s;
   logic [63:0] prod_u_s;
   logic [31:0] a_mag_s;
   logic [31:0] b_mag_s;
   logic [31:0] b_safe_s;
   logic [31:0] sq_mag_s;
   logic [31:0] sr_mag_s;
   logic [31:0] s_quo_s;
   logic [31:0] s_rem_s;
   logic [31:0] u_div_s;
   logic [31:0] u_quo_s;
   logic [31:0] u_rem_s;

   // The low 64 bits of a product of sign-extended operands equal the signed product.
   assign prod_s_s = {{32{A1[31]}}, A1} * {{32{A2[31]}}, A2};
   assign prod_u_s = {32'd0, A1} * {32'd0, A2};

   // Signed divide on magnitudes; 0x80000000 negates to itself, which is the
   // correct unsigned magnitude.
   assign a_mag_s  = A1[31] ? (32'd0 - A1) : A1;
   assign b_mag_s  = A2[31] ? (32'd0 - A2) : A2;
   assign b_safe_s = (A2 == 32'd0) ? 32'd1 : b_mag_s;
   assign sq_mag_s = a_mag_s / b_safe_s;
   assign sr_mag_s = a_mag_s % b_safe_s;
   assign s_quo_s  = (A1[31] ^ A2[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
   assign s_rem_s  = A1[31] ? (32'd0 - sr_mag_s) : sr_mag_s;

   assign u_div_s  = (A2 == 32'd0) ? 32'd1 : A2;
   assign u_quo_s  = A1 / u_div_s;
   assign u_rem_s  = A1 % u_div_s;

`ifndef HILO_MADD_EN
   logic unused_hilo_s;
   assign unused_hilo_s = ^hilo;
`endif

   // Result select by command, with divide special cases ahead of the general path.
   always_comb begin
      result = 64'd0;
      case (md_op)
         MD_MULT:  result = prod_s_s;
         MD_MULTU: result = prod_u_s;
         MD_DIV: begin
            if (A2 == 32'd0) begin
               result = {A1, 32'hFFFF_FFFF};
            end else if ((A1 == 32'h8000_0000) && (A2 == 32'hFFFF_FFFF)) begin
               result = {32'd0, 32'h8000_0000};
            end else begin
               result = {s_rem_s, s_quo_s};
            end
         end
         MD_DIVU: begin
            if (A2 == 32'd0) begin
               result = {A1, 32'hFFFF_FFFF};
            end else begin
               result = {u_rem_s, u_quo_s};
            end
         end
`ifdef HILO_MADD_EN
         MD_MADD:  result = hilo + prod_s_s;
         MD_MADDU: result = hilo + prod_u_s;
         MD_MSUB:  result = hilo - prod_s_s;
         MD_MSUBU: result = hilo - prod_u_s;
`else
         MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: result = 64'd0;
`endif
         default: result = 64'd0;
      endcase
   end

endmodule

// File: rtl/hilo_md_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_md_ctrl
// Sequences the multiply/divide resource and owns the Hi/Lo register pair.
// A long command (mult/div family) latches its result into a pending register
// at acceptance, holds busy for MULT_LAT or DIV_LAT cycles and then commits
// Hi/Lo together. mthi/mtlo write immediately. flush discards in-flight work.
// Optional feature macro: HILO_MADD_EN (madd/maddu/msub/msubu commands).
// Parameters: MULT_LAT (1..31), DIV_LAT (1..31).
// Ports:
//   clk      in  1   rising-edge clock
//   reset_n  in  1   synchronous active-low reset
//   start    in  1   command valid this cycle
//   md_op    in  4   command code
//   A1       in  32  rs operand
//   A2       in  32  rt operand
//   flush    in  1   cancel in-flight operation / suppress start
//   busy     out 1   operation in flight
//   Hi       out 32  Hi register
//   Lo       out 32  Lo register
// -----------------------------------------------------------------------------
module hilo_md_ctrl
   import hilo_md_pkg::*;
#(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] A1,
   input  logic [31:0] A2,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   md_state_t          state_r, state_nxt;
   logic [CNT_W-1:0]   cnt_r, cnt_nxt;
   logic [63:0]        pend_r, pend_nxt;
   logic [31:0]        hi_r, hi_nxt;
   logic [31:0]        lo_r, lo_nxt;
   logic               busy_r, busy_nxt;
   logic [63:0]        calc_res_s;

   hilo_md_calc u_calc (
      .md_op  (md_op),
      .A1     (A1),
      .A2     (A2),
      .hilo   ({hi_r, lo_r}),
      .result (calc_res_s)
   );

   // Next-state, counter, pending result and Hi/Lo update.
   always_comb begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
      pend_nxt  = pend_r;
      hi_nxt    = hi_r;
      lo_nxt    = lo_r;
      busy_nxt  = busy_r;
      case (state_r)
         ST_IDLE: begin
            busy_nxt = 1'b0;
            if (start && !flush) begin
               if (is_mult_op(md_op)) begin
                  pend_nxt  = calc_res_s;
                  cnt_nxt   = CNT_W'(MULT_LAT);
                  state_nxt = ST_RUN;
                  busy_nxt  = 1'b1;
               end else if (is_div_op(md_op)) begin
                  pend_nxt  = calc_res_s;
                  cnt_nxt   = CNT_W'(DIV_LAT);
                  state_nxt = ST_RUN;
                  busy_nxt  = 1'b1;
               end else begin
                  case (md_op)
                     MD_MTHI: hi_nxt = A1;
                     MD_MTLO: lo_nxt = A1;
                     MD_NONE: hi_nxt = hi_r;
                     default: hi_nxt = hi_r;
                  endcase
               end
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            // flush beats the commit edge, so it is tested first.
            if (flush) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
               pend_nxt  = 64'd0;
               busy_nxt  = 1'b0;
            end else if (cnt_r == CNT_W'(1)) begin
               hi_nxt    = pend_r[63:32];
               lo_nxt    = pend_r[31:0];
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
               pend_nxt  = 64'd0;
               busy_nxt  = 1'b0;
            end else begin
               cnt_nxt   = cnt_r - CNT_W'(1);
               busy_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            pend_nxt  = 64'd0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         pend_r  <= 64'd0;
         hi_r    <= 32'd0;
         lo_r    <= 32'd0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt;
         cnt_r   <= cnt_nxt;
         pend_r  <= pend_nxt;
         hi_r    <= hi_nxt;
         lo_r    <= lo_nxt;
         busy_r  <= busy_nxt;
      end
   end

   assign busy = busy_r;
   assign Hi   = hi_r;
   assign Lo   = lo_r;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_md_ctrl
// Self-checking bench for hilo_md_ctrl: directed cases followed by randomized
// commands, flushes and intrusive starts, compared against a transaction-level
// reference model of Hi/Lo.
// Optional feature macro: HILO_MADD_EN (adds madd checks to the model).
// -----------------------------------------------------------------------------
module tb_hilo_md_ctrl;

   localparam int ML = 5;
   localparam int DL = 10;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] A1;
   logic [31:0] A2;
   logic        flush;
   logic        busy;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_hi;
   logic [31:0] m_lo;

   hilo_md_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .md_op   (md_op),
      .A1      (A1),
      .A2      (A2),
      .flush   (flush),
      .busy    (busy),
      .Hi      (Hi),
      .Lo      (Lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_is_long(input logic [3:0] op);
`ifdef HILO_MADD_EN
      return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10);
`else
      return (op >= 4'd1 && op <= 4'd4);
`endif
   endfunction

   function automatic int ref_lat(input logic [3:0] op);
      return (op == OP_DIV || op == OP_DIVU) ? DL : ML;
   endfunction

   // Architectural result {hi,lo} of a long command.
   function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a1,
                                              input logic [31:0] a2, input logic [63:0] acc);
      int          sa, sb, q, r;
      longint      ps;
      longint unsigned pu;
      sa = a1;
      sb = a2;
      ps = longint'(sa) * longint'(sb);
      pu = longint'({32'd0, a1}) * longint'({32'd0, a2});
      case (op)
         OP_MULT:  return ps;
         OP_MULTU: return pu;
         OP_DIV: begin
            if (a2 == 32'd0) return {a1, 32'hFFFF_FFFF};
            if (a1 == 32'h8000_0000 && a2 == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {r, q};
         end
         OP_DIVU: begin
            if (a2 == 32'd0) return {a1, 32'hFFFF_FFFF};
            return {a1 % a2, a1 / a2};
         end
         4'd7:  return acc + ps;
         4'd8:  return acc + pu;
         4'd9:  return acc - ps;
         4'd10: return acc - pu;
         default: return acc;
      endcase
   endfunction

   // Long command; flush_k / intr_k name the busy cycle (1..LAT) on which a
   // flush or an intruding start is driven, 0 for none.
   task automatic run_long(input logic [3:0] op, input logic [31:0] a1, input logic [31:0] a2,
                           input int flush_k, input int intr_k);
      int lat;
      logic [63:0] expv;
      lat  = ref_lat(op);
      expv = ref_result(op, a1, a2, {m_hi, m_lo});
      @(negedge clk);
      start = 1'b1; md_op = op; A1 = a1; A2 = a2;
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= lat; i++) begin
         chk("busy_run", 64'(busy), 64'd1);
         chk("hilo_hold", {Hi, Lo}, {m_hi, m_lo});
         if (i == flush_k) begin
            flush = 1'b1;
         end else if (i == intr_k) begin
            start = 1'b1; md_op = OP_MULT; A1 = $urandom; A2 = $urandom;
         end
         @(negedge clk);
         flush = 1'b0;
         start = 1'b0;
         if (i == flush_k) begin
            chk("busy_flush", 64'(busy), 64'd0);
            chk("hilo_flush", {Hi, Lo}, {m_hi, m_lo});
            return;
         end
      end
      m_hi = expv[63:32];
      m_lo = expv[31:0];
      chk("busy_done", 64'(busy), 64'd0);
      chk("hilo_commit", {Hi, Lo}, expv);
   endtask

   // Single-cycle or ignored command, optionally with flush in the same cycle.
   task automatic run_short(input logic [3:0] op, input logic [31:0] a1, input logic fl);
      @(negedge clk);
      start = 1'b1; md_op = op; A1 = a1; A2 = $urandom; flush = fl;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      if (!fl && op == OP_MTHI) m_hi = a1;
      if (!fl && op == OP_MTLO) m_lo = a1;
      chk("busy_short", 64'(busy), 64'd0);
      chk("hilo_short", {Hi, Lo}, {m_hi, m_lo});
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      m_hi = 32'd0;
      m_lo = 32'd0;
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; md_op = 4'd0; A1 = 32'd0; A2 = 32'd0; flush = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_hilo", {Hi, Lo}, 64'd0);
      reset_n = 1'b1;

      // Directed cases with hand-derived values.
      run_long(OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);
      chk("mult_neg", {Hi, Lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
      run_long(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      chk("multu_max", {Hi, Lo}, {32'hFFFF_FFFE, 32'h0000_0001});
      run_long(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
      chk("div_neg", {Hi, Lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_long(OP_DIVU, 32'd5, 32'd0, 0, 0);
      chk("divu_zero", {Hi, Lo}, {32'd5, 32'hFFFF_FFFF});
      run_long(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      chk("div_ovf", {Hi, Lo}, {32'd0, 32'h8000_0000});
      run_short(OP_MTHI, 32'h1234_5678, 1'b0);
      chk("mthi", 64'(Hi), 64'h1234_5678);
      run_long(OP_DIV, 32'd100, 32'd7, 4, 0);
      chk("flush_keep_hi", 64'(Hi), 64'h1234_5678);
      run_long(OP_DIV, 32'd100, 32'd7, DL, 0);
      run_long(OP_DIV, 32'd100, 32'd7, 0, 3);
      chk("intrude_div", {Hi, Lo}, {32'd2, 32'd14});
      run_short(OP_MTLO, 32'hDEAD_BEEF, 1'b1);

      // Reset in the middle of a divide.
      @(negedge clk);
      start = 1'b1; md_op = OP_DIV; A1 = 32'd77; A2 = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midrun_rst_busy", 64'(busy), 64'd0);
      chk("midrun_rst_hilo", {Hi, Lo}, 64'd0);
      reset_n = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      @(negedge clk);
      chk("post_rst_idle", 64'(busy), 64'd0);

`ifdef HILO_MADD_EN
      run_short(OP_MTLO, 32'd10, 1'b0);
      run_long(OP_MADD, 32'd3, 32'd4, 0, 0);
      chk("madd", {Hi, Lo}, {32'd0, 32'd22});
`endif

      // Randomized commands, operands, flushes and intrusions.
      for (int n = 0; n < 80; n++) begin
         logic [3:0]  op;
         logic [31:0] a1, a2;
         int          lat, fk, ik;
         op = 4'($urandom_range(0, 15));
         a1 = $urandom;
         a2 = $urandom;
         case ($urandom_range(0, 5))
            0: a2 = 32'd0;
            1: a2 = 32'($urandom_range(1, 9));
            2: begin a1 = 32'h8000_0000; a2 = 32'hFFFF_FFFF; end
            default: a1 = a1;
         endcase
         if (ref_is_long(op)) begin
            lat = ref_lat(op);
            fk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
            ik = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
            run_long(op, a1, a2, fk, ik);
         end else begin
            run_short(op, a1, ($urandom_range(0, 4) == 0));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
